cpu_telemetry_tx: RTL and testbench

//  Transmit half of the CPU link. It frames telemetry packets from the comms register memory into a byte stream for the CPU-side serial transmitter.
//  A request supplies ID, payload length and base address. The block fetches payload bytes through a 1-cycle-latency read port.
//  It emits SYNC, ID, LEN, [timestamp], payload and checksum over a valid/ready byte interface.

---
 rtl/cpu_telemetry_tx_pkg.sv | 34 +++
 rtl/cpu_telemetry_tx_if.sv | 31 +++
 rtl/cpu_telemetry_tx_timer.sv | 31 +++
 rtl/cpu_telemetry_tx.sv | 158 +++++++++++++++
 tb/tb_cpu_telemetry_tx.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_telemetry_tx_pkg.sv
// Shared constants and FSM state type for the CPU telemetry transmitter.
// TLM_HDR_BYTES follows the optional timestamp build (TLM_TIMESTAMP_EN).
package cpu_telemetry_tx_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef TLM_TIMESTAMP_EN
  localparam int TLM_HDR_BYTES = 7;
`else
  localparam int TLM_HDR_BYTES = 3;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ID,
    ST_LEN,
    ST_TS3,
    ST_TS2,
    ST_TS1,
    ST_TS0,
    ST_FETCH,
    ST_PAYLOAD,
    ST_CSUM,
    ST_DONE
  } tlm_tx_state_t;

  // Bytes folded into the running checksum; SYNC and CSUM itself are excluded.
  function automatic logic in_checksum(input tlm_tx_state_t s);
    return (s == ST_ID) || (s == ST_LEN) || (s == ST_TS3) || (s == ST_TS2) ||
           (s == ST_TS1) || (s == ST_TS0) || (s == ST_PAYLOAD);
  endfunction

endpackage

// File: rtl/cpu_telemetry_tx_if.sv
// Request, memory read port and byte stream of the telemetry transmitter.
// The transmitter is the slave; the requester/memory/serialiser side is the master.
interface cpu_telemetry_tx_if #(
  parameter int ADDR_W = 8
) ();

  logic              tx_req;
  logic [7:0]        tx_id;
  logic [7:0]        tx_len;
  logic [ADDR_W-1:0] tx_base;
  logic              tx_busy;
  logic              tx_done;
  logic              tx_err_len;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_rd_data;
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_ready;

  modport slave (
    input  tx_req, tx_id, tx_len, tx_base, mem_rd_data, byte_ready,
    output tx_busy, tx_done, tx_err_len, mem_rd_en, mem_addr, byte_data, byte_valid
  );

  modport master (
    output tx_req, tx_id, tx_len, tx_base, mem_rd_data, byte_ready,
    input  tx_busy, tx_done, tx_err_len, mem_rd_en, mem_addr, byte_data, byte_valid
  );

endinterface

// File: rtl/cpu_telemetry_tx_timer.sv
// Free-running microsecond counter: prescaler of SYSCLK_FREQ/1e6 clocks feeding a
// wrapping 32-bit count. Only instantiated when TLM_TIMESTAMP_EN is defined.
module tlm_us_timer #(
  parameter int SYSCLK_FREQ = 100_000_000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] o_us
);

  localparam int DIV = (SYSCLK_FREQ / 1_000_000 > 1) ? SYSCLK_FREQ / 1_000_000 : 1;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_pre;
  logic [31:0]   r_us;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pre <= '0;
      r_us  <= '0;
    end else if (r_pre == PW'(DIV - 1)) begin
      r_pre <= '0;
      r_us  <= r_us + 32'd1;
    end else begin
      r_pre <= r_pre + PW'(1);
    end
  end

  assign o_us = r_us;

endmodule

// File: rtl/cpu_telemetry_tx.sv
// Frames SYNC, ID, LEN, [TS3..TS0], payload, CSUM from register memory onto a
// valid/ready byte stream. Timestamp bytes exist only with TLM_TIMESTAMP_EN.
import cpu_telemetry_tx_pkg::*;

module cpu_telemetry_tx #(
  parameter int SYSCLK_FREQ = 100_000_000,
  parameter int ADDR_W      = 8,
  parameter int MAX_PAYLOAD = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  cpu_telemetry_tx_if.slave     bus
);

  tlm_tx_state_t     r_state;
  tlm_tx_state_t     w_state_next;
  logic [7:0]        r_id;
  logic [7:0]        r_len;
  logic [ADDR_W-1:0] r_base;
  logic [7:0]        r_idx;
  logic [7:0]        r_sum;
  logic [7:0]        r_pay_data;
  logic              r_rd_pending;
  logic              r_err_len;

  logic              w_accept;
  logic              w_reject;
  logic              w_hs;
  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic [7:0]        w_pay_byte;
  logic [7:0]        w_idx_inc;

`ifdef TLM_TIMESTAMP_EN
  logic [31:0] w_us;
  logic [31:0] r_ts;

  tlm_us_timer #(.SYSCLK_FREQ(SYSCLK_FREQ)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .o_us (w_us)
  );
`endif

  assign w_accept  = (r_state == ST_IDLE) && bus.tx_req && (int'(bus.tx_len) <= MAX_PAYLOAD);
  assign w_reject  = (r_state == ST_IDLE) && bus.tx_req && (int'(bus.tx_len) >  MAX_PAYLOAD);
  assign w_hs      = w_byte_valid && bus.byte_ready;
  assign w_idx_inc = r_idx + 8'd1;

  // Read data is live on the port only in the first PAYLOAD cycle; hold it after that.
  assign w_pay_byte = r_rd_pending ? bus.mem_rd_data : r_pay_data;

  always_comb begin
    w_state_next = r_state;
    w_byte_valid = 1'b0;
    w_byte_data  = 8'h00;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = ST_SYNC;
      ST_SYNC: begin
        w_byte_valid = 1'b1;
        w_byte_data  = SYNC_BYTE;
        if (w_hs) w_state_next = ST_ID;
      end
      ST_ID: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_id;
        if (w_hs) w_state_next = ST_LEN;
      end
      ST_LEN: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_len;
`ifdef TLM_TIMESTAMP_EN
        if (w_hs) w_state_next = ST_TS3;
`else
        if (w_hs) w_state_next = (r_len == 8'd0) ? ST_CSUM : ST_FETCH;
`endif
      end
`ifdef TLM_TIMESTAMP_EN
      ST_TS3: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_ts[31:24];
        if (w_hs) w_state_next = ST_TS2;
      end
      ST_TS2: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_ts[23:16];
        if (w_hs) w_state_next = ST_TS1;
      end
      ST_TS1: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_ts[15:8];
        if (w_hs) w_state_next = ST_TS0;
      end
      ST_TS0: begin
        w_byte_valid = 1'b1;
        w_byte_data  = r_ts[7:0];
        if (w_hs) w_state_next = (r_len == 8'd0) ? ST_CSUM : ST_FETCH;
      end
`endif
      ST_FETCH: w_state_next = ST_PAYLOAD;
      ST_PAYLOAD: begin
        w_byte_valid = 1'b1;
        w_byte_data  = w_pay_byte;
        if (w_hs) w_state_next = (w_idx_inc < r_len) ? ST_FETCH : ST_CSUM;
      end
      ST_CSUM: begin
        w_byte_valid = 1'b1;
        w_byte_data  = 8'h00 - r_sum;
        if (w_hs) w_state_next = ST_DONE;
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_id         <= '0;
      r_len        <= '0;
      r_base       <= '0;
      r_idx        <= '0;
      r_sum        <= '0;
      r_pay_data   <= '0;
      r_rd_pending <= 1'b0;
      r_err_len    <= 1'b0;
`ifdef TLM_TIMESTAMP_EN
      r_ts         <= '0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_err_len    <= w_reject;
      r_rd_pending <= (r_state == ST_FETCH);
      if (w_accept) begin
        r_id   <= bus.tx_id;
        r_len  <= bus.tx_len;
        r_base <= bus.tx_base;
        r_idx  <= '0;
        r_sum  <= '0;
`ifdef TLM_TIMESTAMP_EN
        r_ts   <= w_us;
`endif
      end
      if (w_hs && in_checksum(r_state)) r_sum <= r_sum + w_byte_data;
      if ((r_state == ST_PAYLOAD) && r_rd_pending) r_pay_data <= bus.mem_rd_data;
      if (w_hs && (r_state == ST_PAYLOAD)) r_idx <= w_idx_inc;
    end
  end

  assign bus.tx_busy    = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign bus.tx_done    = (r_state == ST_DONE);
  assign bus.tx_err_len = r_err_len;
  assign bus.mem_rd_en  = (r_state == ST_FETCH);
  assign bus.mem_addr   = (r_state == ST_FETCH) ? (r_base + ADDR_W'(r_idx)) : '0;
  assign bus.byte_data  = w_byte_data;
  assign bus.byte_valid = w_byte_valid;

endmodule

// File: tb/tb_cpu_telemetry_tx.sv
// Self-checking bench for cpu_telemetry_tx: directed and random frames compared
// against a frame model built from the packet rules; TS bytes taken as sent when TLM_TIMESTAMP_EN.
module tb_cpu_telemetry_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;

  cpu_telemetry_tx_if #(.ADDR_W(8)) bus ();

  cpu_telemetry_tx #(
    .SYSCLK_FREQ (100_000_000),
    .ADDR_W      (8),
    .MAX_PAYLOAD (64)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Register memory with 1-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends one request, collects the frame under the chosen ready pattern, checks it.
  task automatic run_frame(input logic [7:0] id, input logic [7:0] len,
                           input logic [7:0] base, input bit rnd_ready);
    logic [7:0] got_q[$];
    logic [7:0] addr_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] sum;
    logic [7:0] prev_data;
    bit   prev_stall;
    bit   done_seen;
    int   cyc;
    int   n;
    prev_stall = 0;
    done_seen  = 0;
    prev_data  = 8'h00;
    cyc        = 0;
    bus.tx_req  = 1'b1;
    bus.tx_id   = id;
    bus.tx_len  = len;
    bus.tx_base = base;
    @(posedge clk); #1;
    bus.tx_req = 1'b0;
    while (!done_seen && cyc < 2000) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.byte_valid), 32'd1);
        chk("stall_data", 32'(bus.byte_data), 32'(prev_data));
      end
      if (bus.mem_rd_en) addr_q.push_back(bus.mem_addr);
      if (bus.tx_done) begin
        done_seen = 1;
        chk("busy_at_done", 32'(bus.tx_busy), 32'd0);
      end
      bus.byte_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.byte_valid && bus.byte_ready) got_q.push_back(bus.byte_data);
      prev_stall = bus.byte_valid && !bus.byte_ready;
      prev_data  = bus.byte_data;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", 32'(done_seen), 32'd1);
    chk("done_pulse_width", 32'(bus.tx_done), 32'd0);
    bus.byte_ready = 1'b1;

    exp_q.push_back(8'hA5);
    exp_q.push_back(id);
    exp_q.push_back(len);
`ifdef TLM_TIMESTAMP_EN
    for (int i = 3; i < 7; i++) exp_q.push_back((got_q.size() > i) ? got_q[i] : 8'h00);
`endif
    for (int i = 0; i < len; i++) exp_q.push_back(mem[8'(base + 8'(i))]);
    sum = 8'h00;
    for (int i = 1; i < exp_q.size(); i++) sum = sum + exp_q[i];
    exp_q.push_back(8'h00 - sum);

    chk($sformatf("id%02h_frame_len", id), 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("id%02h_byte%0d", id, i), 32'(got_q[i]), 32'(exp_q[i]));
    chk($sformatf("id%02h_rd_count", id), 32'(addr_q.size()), 32'(len));
    n = (addr_q.size() < int'(len)) ? addr_q.size() : int'(len);
    for (int i = 0; i < n; i++)
      chk($sformatf("id%02h_addr%0d", id, i), 32'(addr_q[i]), 32'(8'(base + 8'(i))));
    $display("frame id=%02h len=%0d base=%02h rnd_ready=%0d bytes=%0d", id, len, base, rnd_ready, got_q.size());
  endtask

  initial begin
    int err_cnt;
    int valid_cnt;
    int busy_cnt;
    int done_cnt;
    int got;
    int cyc;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h20] = 8'h01;
    mem[8'h21] = 8'h02;
    mem[8'h22] = 8'h03;
    bus.tx_req      = 1'b0;
    bus.tx_id       = 8'h00;
    bus.tx_len      = 8'h00;
    bus.tx_base     = 8'h00;
    bus.byte_ready  = 1'b0;
    bus.mem_rd_data = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",   32'(bus.tx_busy),    32'd0);
    chk("rst_done",   32'(bus.tx_done),    32'd0);
    chk("rst_err",    32'(bus.tx_err_len), 32'd0);
    chk("rst_valid",  32'(bus.byte_valid), 32'd0);
    chk("rst_data",   32'(bus.byte_data),  32'd0);
    chk("rst_rd_en",  32'(bus.mem_rd_en),  32'd0);
    chk("rst_addr",   32'(bus.mem_addr),   32'd0);
    rst = 1'b0;
    bus.byte_ready = 1'b1;
    @(posedge clk); #1;

    // Directed frames: basic, empty payload, address wrap, random stalls, max length.
    run_frame(8'h10, 8'd3, 8'h20, 1'b0);
    run_frame(8'h7F, 8'd0, 8'h00, 1'b0);
    run_frame(8'h33, 8'd4, 8'hFE, 1'b0);
    run_frame(8'h10, 8'd3, 8'h20, 1'b1);
    run_frame(8'hC4, 8'd64, 8'hE0, 1'b1);

    // Over-length request is rejected without touching the stream.
    err_cnt = 0; valid_cnt = 0; busy_cnt = 0;
    bus.tx_req = 1'b1; bus.tx_id = 8'h55; bus.tx_len = 8'd65; bus.tx_base = 8'h00;
    @(posedge clk); #1;
    bus.tx_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (bus.tx_err_len)  err_cnt++;
      if (bus.byte_valid)  valid_cnt++;
      if (bus.tx_busy)     busy_cnt++;
      @(posedge clk); #1;
    end
    chk("len65_err_pulses", 32'(err_cnt),   32'd1);
    chk("len65_valid",      32'(valid_cnt), 32'd0);
    chk("len65_busy",       32'(busy_cnt),  32'd0);
    $display("reject len=65 err_pulses=%0d", err_cnt);

    // Random frames.
    for (int t = 0; t < 8; t++)
      run_frame(8'($urandom), 8'($urandom_range(0, 64)), 8'($urandom), 1'($urandom_range(0, 1)));

    // Reset during the second payload byte abandons the frame.
    bus.tx_req = 1'b1; bus.tx_id = 8'h5A; bus.tx_len = 8'd5; bus.tx_base = 8'h40;
    @(posedge clk); #1;
    bus.tx_req = 1'b0;
    got = 0; cyc = 0;
    while (!(got >= 4 && bus.byte_valid) && cyc < 200) begin
      if (bus.byte_valid && bus.byte_ready) got++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("rst_mid_reached", 32'(got >= 4 && bus.byte_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", 32'(bus.byte_valid), 32'd0);
    chk("rst_mid_busy",  32'(bus.tx_busy),    32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.tx_done) done_cnt++;
      @(posedge clk); #1;
    end
    chk("rst_mid_no_done", 32'(done_cnt), 32'd0);
    $display("reset mid-payload after %0d bytes, tx_done count=%0d", got, done_cnt);
    run_frame(8'h5A, 8'd5, 8'h40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
